// File: rtl/bch2_serial_decoder.sv
// Bit-serial double-error-correcting BCH decoder over GF(2^M): serial syndromes, scaled locator, Chien search.
// Define BCH_STATS_EN to add stat_clear and the stat_words/stat_corrected/stat_uncorrectable counters.
module bch2_serial_decoder #(
  parameter int         M         = 4,
  parameter logic [M:0] PRIM_POLY = 5'b10011,
  localparam int        N         = (1 << M) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_word,
  output logic [1:0]   out_err_count,
  output logic         out_error_flag,
  output logic         out_uncorrectable
`ifdef BCH_STATS_EN
  ,
  input  logic         stat_clear,
  output logic [15:0]  stat_words,
  output logic [15:0]  stat_corrected,
  output logic [15:0]  stat_uncorrectable
`endif
);

  typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, OUT} state_t;

  function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  // The polynomial's constant term clears bit 0, so the shift is exact.
  function automatic logic [M-1:0] mul_ainv(input logic [M-1:0] x);
    logic [M:0] t;
    t = {1'b0, x} ^ (x[0] ? PRIM_POLY : '0);
    return t[M:1];
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) p = mul_a(p) ^ (b[i] ? a : '0);
    return p;
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] rx_q, rx_d;
  logic [N-1:0] corr_q, corr_d;
  logic [M-1:0] s1_q, s1_d, s3_q, s3_d;
  logic [M-1:0] sig0_q, sig0_d, t1_q, t1_d, t2_q, t2_d;
  logic [1:0]   deg_q, deg_d, roots_q, roots_d;
  logic         invalid_q, invalid_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_word_q, out_word_d;
  logic [1:0]   out_err_count_q, out_err_count_d;
  logic         out_error_flag_q, out_error_flag_d;
  logic         out_unc_q, out_unc_d;

  logic [M-1:0] r_bit, key_sq, key_sigma2;
  logic         eval_en, is_root;

  assign r_bit      = {{(M-1){1'b0}}, corr_q[N-1]};
  assign key_sq     = gf_mul(s1_q, s1_q);
  assign key_sigma2 = gf_mul(key_sq, s1_q) ^ s3_q;
  // Degree-0 words make every position a root and invalid words are not searched.
  assign eval_en    = !invalid_q && (deg_q != 2'd0);
  assign is_root    = eval_en && ((sig0_q ^ t1_q ^ t2_q) == '0);

  always_comb begin
    state_d          = state_q;
    rx_d             = rx_q;
    corr_d           = corr_q;
    s1_d             = s1_q;
    s3_d             = s3_q;
    sig0_d           = sig0_q;
    t1_d             = t1_q;
    t2_d             = t2_q;
    deg_d            = deg_q;
    roots_d          = roots_q;
    invalid_d        = invalid_q;
    cnt_d            = cnt_q;
    out_valid_d      = out_valid_q;
    out_word_d       = out_word_q;
    out_err_count_d  = out_err_count_q;
    out_error_flag_d = out_error_flag_q;
    out_unc_d        = out_unc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rx_d    = in_word;
          corr_d  = in_word;
          s1_d    = '0;
          s3_d    = '0;
          cnt_d   = '0;
          state_d = SYND;
        end
      end
      // corr rotates left so the MSB is consumed first; N rotations restore it.
      SYND: begin
        s1_d   = mul_a(s1_q) ^ r_bit;
        s3_d   = mul_a(mul_a(mul_a(s3_q))) ^ r_bit;
        corr_d = {corr_q[N-2:0], corr_q[N-1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == M'(N - 1)) begin
          cnt_d   = '0;
          state_d = KEY;
        end
      end
      KEY: begin
        sig0_d    = s1_q;
        t1_d      = key_sq;
        t2_d      = key_sigma2;
        roots_d   = 2'd0;
        cnt_d     = '0;
        invalid_d = (s1_q == '0) && (s3_q != '0);
        if (s1_q == '0)             deg_d = 2'd0;
        else if (key_sigma2 == '0)  deg_d = 2'd1;
        else                        deg_d = 2'd2;
        state_d   = CHIEN;
      end
      // Rotating right brings bit k to position 0 on step k.
      CHIEN: begin
        if (cnt_q == M'(N)) begin
          out_valid_d      = 1'b1;
          out_error_flag_d = (s1_q | s3_q) != '0;
          if (invalid_q || (roots_q != deg_q)) begin
            out_unc_d       = 1'b1;
            out_word_d      = rx_q;
            out_err_count_d = 2'd0;
          end else begin
            out_unc_d       = 1'b0;
            out_word_d      = corr_q;
            out_err_count_d = roots_q;
          end
          state_d = OUT;
        end else begin
          corr_d = {corr_q[0] ^ is_root, corr_q[N-1:1]};
          if (is_root) roots_d = roots_q + 2'd1;
          t1_d  = mul_ainv(t1_q);
          t2_d  = mul_ainv(mul_ainv(t2_q));
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      rx_q             <= '0;
      corr_q           <= '0;
      s1_q             <= '0;
      s3_q             <= '0;
      sig0_q           <= '0;
      t1_q             <= '0;
      t2_q             <= '0;
      deg_q            <= '0;
      roots_q          <= '0;
      invalid_q        <= 1'b0;
      cnt_q            <= '0;
      out_valid_q      <= 1'b0;
      out_word_q       <= '0;
      out_err_count_q  <= '0;
      out_error_flag_q <= 1'b0;
      out_unc_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      rx_q             <= rx_d;
      corr_q           <= corr_d;
      s1_q             <= s1_d;
      s3_q             <= s3_d;
      sig0_q           <= sig0_d;
      t1_q             <= t1_d;
      t2_q             <= t2_d;
      deg_q            <= deg_d;
      roots_q          <= roots_d;
      invalid_q        <= invalid_d;
      cnt_q            <= cnt_d;
      out_valid_q      <= out_valid_d;
      out_word_q       <= out_word_d;
      out_err_count_q  <= out_err_count_d;
      out_error_flag_q <= out_error_flag_d;
      out_unc_q        <= out_unc_d;
    end
  end

  assign in_ready          = (state_q == IDLE) && !rst;
  assign out_valid         = out_valid_q;
  assign out_word          = out_word_q;
  assign out_err_count     = out_err_count_q;
  assign out_error_flag    = out_error_flag_q;
  assign out_uncorrectable = out_unc_q;

`ifdef BCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_corr_q, stat_corr_d;
  logic [15:0] stat_unc_q, stat_unc_d;
  logic        out_fire;

  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_corr_d  = stat_corr_q;
    stat_unc_d   = stat_unc_q;
    if (stat_clear) begin
      stat_words_d = '0;
      stat_corr_d  = '0;
      stat_unc_d   = '0;
    end else if (out_fire) begin
      stat_words_d = sat_inc(stat_words_q);
      if ((out_err_count_q != 2'd0) && !out_unc_q) stat_corr_d = sat_inc(stat_corr_q);
      if (out_unc_q) stat_unc_d = sat_inc(stat_unc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_corr_q  <= '0;
      stat_unc_q   <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_corr_q  <= stat_corr_d;
      stat_unc_q   <= stat_unc_d;
    end
  end

  assign stat_words         = stat_words_q;
  assign stat_corrected     = stat_corr_q;
  assign stat_uncorrectable = stat_unc_q;
`endif

endmodule

// File: tb/tb_bch2_serial_decoder.sv
// Scoreboard bench for bch2_serial_decoder: a GF(16) instance under random traffic and backpressure,
// plus a GF(32) instance for a single directed word.
module tb_bch2_serial_decoder;

   localparam int M        = 4;
   localparam int N        = 15;
   localparam int LAT      = 2 * N + 2;
   localparam int PRIM_INT = 'h13;
   localparam int N5       = 31;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0]  in_word, out_word;
   logic [1:0]    out_err_count;
   logic          out_error_flag, out_uncorrectable;

   logic          in_valid5, in_ready5, out_valid5, out_ready5;
   logic [N5-1:0] in_word5, out_word5;
   logic [1:0]    out_err_count5;
   logic          out_error_flag5, out_uncorrectable5;

`ifdef BCH_STATS_EN
   logic          stat_clear, stat_clear5;
   logic [15:0]   stat_words, stat_corrected, stat_uncorrectable;
   logic [15:0]   stat_words5, stat_corrected5, stat_uncorrectable5;
`endif

   typedef struct {
      logic [N-1:0] word;
      int           cnt;
      bit           flag;
      bit           unc;
      int           acc;
   } exp_t;

   exp_t          sbq[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            pw[N];
   int            readyMode = 0;
   int            expWords = 0, expCorr = 0, expUnc = 0;
   bit            shown = 0, postHs = 0;
   logic [N-1:0]  heldWord;
   logic [1:0]    heldCnt;
   logic          heldFlag, heldUnc;

   bch2_serial_decoder #(.M(4), .PRIM_POLY(5'b10011)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_err_count(out_err_count), .out_error_flag(out_error_flag),
      .out_uncorrectable(out_uncorrectable)
`ifdef BCH_STATS_EN
      ,
      .stat_clear(stat_clear), .stat_words(stat_words),
      .stat_corrected(stat_corrected), .stat_uncorrectable(stat_uncorrectable)
`endif
   );

   bch2_serial_decoder #(.M(5), .PRIM_POLY(6'b100101)) u_dut5 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_word(in_word5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_word(out_word5),
      .out_err_count(out_err_count5), .out_error_flag(out_error_flag5),
      .out_uncorrectable(out_uncorrectable5)
`ifdef BCH_STATS_EN
      ,
      .stat_clear(stat_clear5), .stat_words(stat_words5),
      .stat_corrected(stat_corrected5), .stat_uncorrectable(stat_uncorrectable5)
`endif
   );

   // Free-running clock and a cycle counter that only changes on the rising edge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sink readiness: random by default, held low or high for the directed backpressure case.
   always @(negedge clk) begin
      if (readyMode == 1)      out_ready = 1'b0;
      else if (readyMode == 2) out_ready = 1'b1;
      else                     out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: syndromes as sums of field powers, then a nearest-codeword search of radius two.
   function automatic int synd1(input logic [N-1:0] w);
      int s = 0;
      for (int p = 0; p < N; p++) if (w[p]) s ^= pw[p];
      return s;
   endfunction

   function automatic int synd3(input logic [N-1:0] w);
      int s = 0;
      for (int p = 0; p < N; p++) if (w[p]) s ^= pw[(3 * p) % N];
      return s;
   endfunction

   function automatic exp_t mkExp(input logic [N-1:0] w, input int c, input bit f, input bit u);
      exp_t e;
      e.word = w; e.cnt = c; e.flag = f; e.unc = u; e.acc = 0;
      return e;
   endfunction

   function automatic exp_t modelDecode(input logic [N-1:0] w);
      exp_t         e;
      logic [N-1:0] one, cand;
      bit           found;
      one   = 1;
      e     = mkExp(w, 0, (synd1(w) != 0) || (synd3(w) != 0), 0);
      found = !e.flag;
      for (int i = 0; i < N && !found; i++) begin
         cand = w ^ (one << i);
         if (synd1(cand) == 0 && synd3(cand) == 0) begin
            e.word = cand; e.cnt = 1; found = 1;
         end
      end
      for (int i = 0; i < N && !found; i++)
         for (int j = i + 1; j < N && !found; j++) begin
            cand = w ^ (one << i) ^ (one << j);
            if (synd1(cand) == 0 && synd3(cand) == 0) begin
               e.word = cand; e.cnt = 2; found = 1;
            end
         end
      if (!found) e.unc = 1;
      return e;
   endfunction

   // Present one word, wait (bounded) for acceptance, and queue its expected result.
   task automatic applyStimulus(input logic [N-1:0] w, input exp_t given, input bit useGiven);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      while (!in_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0 for word %0h", w);
         in_valid = 1'b0;
         return;
      end
      e     = useGiven ? given : modelDecode(w);
      e.acc = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int k = 0;
      do begin
         @(negedge clk); #2;
         k++;
      end while ((sbq.size() != 0 || out_valid) && k < 500);
      if (sbq.size() != 0 || out_valid) begin
         checks++; errors++;
         $display("[TB] FAIL drain_timeout: %0d results still pending", sbq.size());
      end
   endtask

   // Monitor: compares each new result with the scoreboard head, then checks it stays put until taken.
   always begin
      exp_t e;
      @(negedge clk); #1;
      if (rst) begin
         sbq.delete();
         shown = 0; postHs = 0;
         expWords = 0; expCorr = 0; expUnc = 0;
      end else begin
         if (postHs) begin
            checkOutput("valid_drop_after_handshake", out_valid, 0);
            checkOutput("ready_after_handshake", in_ready, 1);
            postHs = 0;
         end
         if (out_valid) begin
            if (!shown) begin
               if (sbq.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_output: word %0h with empty scoreboard", out_word);
               end else begin
                  e = sbq.pop_front();
                  checkOutput("out_word", out_word, e.word);
                  checkOutput("err_count", out_err_count, e.cnt);
                  checkOutput("error_flag", out_error_flag, e.flag);
                  checkOutput("uncorrectable", out_uncorrectable, e.unc);
                  checkOutput("latency", cyc - e.acc, LAT);
               end
               heldWord = out_word; heldCnt = out_err_count;
               heldFlag = out_error_flag; heldUnc = out_uncorrectable;
               shown = 1;
            end else begin
               checkOutput("hold_word", out_word, heldWord);
               checkOutput("hold_count", out_err_count, heldCnt);
               checkOutput("hold_flags", {out_error_flag, out_uncorrectable}, {heldFlag, heldUnc});
            end
            checkOutput("busy_in_ready", in_ready, 0);
            if (out_ready) begin
               shown = 0; postHs = 1;
               expWords++;
               if (out_err_count != 0 && !out_uncorrectable) expCorr++;
               if (out_uncorrectable) expUnc++;
            end
         end
      end
   end

   // Main sequence: reset, directed words, sweeps, backpressure, random traffic, abort, GF(32) word.
   initial begin
      logic [N-1:0] gen, cw, mask, one;
      int           v, nerr, k, acc5;
      gen = 15'h01D1;
      one = 1;
      v = 1;
      for (int i = 0; i < N; i++) begin
         pw[i] = v;
         v = v << 1;
         if ((v & (1 << M)) != 0) v ^= PRIM_INT;
      end
      rst = 1'b1; in_valid = 1'b0; in_word = '0;
      in_valid5 = 1'b0; in_word5 = '0; out_ready5 = 1'b1;
`ifdef BCH_STATS_EN
      stat_clear = 1'b0; stat_clear5 = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_word", out_word, 0);
      checkOutput("reset_flags", {out_err_count, out_error_flag, out_uncorrectable}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      checkOutput("idle_in_ready", in_ready, 1);

      applyStimulus(15'h01D1, mkExp(15'h01D1, 0, 0, 0), 1);
      applyStimulus(15'h01D0, mkExp(15'h01D1, 1, 1, 0), 1);
      applyStimulus(15'h41D3, mkExp(15'h01D1, 2, 1, 0), 1);
      for (int i = 0; i < N; i++)
         applyStimulus(gen ^ (one << i), mkExp(gen, 1, 1, 0), 1);
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            applyStimulus(gen ^ (one << i) ^ (one << j), mkExp(gen, 2, 1, 0), 1);
      waitDrain();

      readyMode = 1;
      fork
         begin
            applyStimulus(15'h01D0, mkExp(15'h01D1, 1, 1, 0), 1);
            applyStimulus(15'h41D3, mkExp(15'h01D1, 2, 1, 0), 1);
         end
         begin
            k = 0;
            while (!out_valid && k < 200) begin
               @(negedge clk);
               k++;
            end
            repeat (10) @(negedge clk);
            readyMode = 2;
         end
      join
      waitDrain();
      readyMode = 0;

      for (int n = 0; n < 150; n++) begin
         cw = '0;
         for (int j = 0; j < 7; j++) if ($urandom_range(0, 1) == 1) cw ^= gen << j;
         nerr = $urandom_range(0, 4);
         mask = '0;
         while ($countones(mask) < nerr) mask |= one << $urandom_range(0, N - 1);
         applyStimulus(cw ^ mask, mkExp('0, 0, 0, 0), 0);
      end
      waitDrain();

`ifdef BCH_STATS_EN
      checkOutput("stat_words", stat_words, expWords);
      checkOutput("stat_corrected", stat_corrected, expCorr);
      checkOutput("stat_uncorrectable", stat_uncorrectable, expUnc);
      @(negedge clk); stat_clear = 1'b1;
      @(negedge clk); stat_clear = 1'b0; #2;
      checkOutput("stat_clear", {stat_words, stat_corrected, stat_uncorrectable}, 0);
`endif

      applyStimulus(15'h01D0, mkExp(15'h01D1, 1, 1, 0), 1);
      repeat (20) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 0);
      checkOutput("abort_out_word", out_word, 0);
      checkOutput("abort_flags", {out_err_count, out_error_flag, out_uncorrectable}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(15'h01D0, mkExp(15'h01D1, 1, 1, 0), 1);
      waitDrain();

      @(negedge clk);
      in_valid5 = 1'b1;
      in_word5  = 31'h40000000;
      k = 0;
      while (!in_ready5 && k < 50) begin
         @(negedge clk);
         k++;
      end
      checkOutput("m5_accept", in_ready5, 1);
      acc5 = cyc + 1;
      @(negedge clk);
      in_valid5 = 1'b0;
      k = 0;
      while (!out_valid5 && k < 300) begin
         @(negedge clk);
         k++;
      end
      checkOutput("m5_latency", cyc - acc5, 2 * N5 + 2);
      checkOutput("m5_out_word", out_word5, 0);
      checkOutput("m5_err_count", out_err_count5, 1);
      checkOutput("m5_flags", {out_error_flag5, out_uncorrectable5}, 2'b10);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
